// File: rtl/serial_negate_rx.sv
// serial_negate_rx: frames an LSB-first serial stream into W-bit words and re-negates it bit-serially.
module serial_negate_rx #(
    parameter int W = 8
) (
    input  logic         t_clk,
    input  logic         r,
    input  logic         i,
    input  logic         v,
    input  logic         f,
    output logic [W-1:0] q,
    output logic         q_v,
    input  logic         q_rdy,
    output logic         mn,
    output logic         fe,
    output logic         ovf
);
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [W-1:0]  word_q, word_d;
    logic          qv_q, qv_d;
    logic          mn_q, mn_d;
    logic          fe_q, fe_d;
    logic          ovf_q, ovf_d;
    logic          start, take, done, seen_in, o;

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            sr_q    <= '0;
            word_q  <= '0;
            qv_q    <= 1'b0;
            mn_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            qv_q    <= qv_d;
            mn_q    <= mn_d;
            fe_q    <= fe_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seen_d  = seen_q;
        sr_d    = sr_q;
        word_d  = word_q;
        qv_d    = (qv_q && q_rdy) ? 1'b0 : qv_q;
        mn_d    = mn_q;
        fe_d    = 1'b0;
        ovf_d   = ovf_q;
        start   = v && f;
        take    = v && (state_q == SHIFT || f);
        // A restart always begins with seen cleared; leftover sr bits are shifted out before completion.
        seen_in = start ? 1'b0 : seen_q;
        o       = i ^ seen_in;
        done    = take && !start && state_q == SHIFT && cnt_q == CW'(W - 1);
        if (take) begin
            sr_d    = {o, sr_q[W-1:1]};
            seen_d  = seen_in | i;
            cnt_d   = start ? CW'(1) : cnt_q + CW'(1);
            fe_d    = start && state_q == SHIFT;
            state_d = SHIFT;
        end
        if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
            seen_d  = 1'b0;
            if (!qv_q || q_rdy) begin
                word_d = sr_d;
                qv_d   = 1'b1;
                mn_d   = sr_d == MOST_NEG;
            end else begin
                ovf_d  = 1'b1;
            end
        end
    end

    assign q   = word_q;
    assign q_v = qv_q;
    assign mn  = mn_q;
    assign fe  = fe_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_negate_rx.sv
// tb_serial_negate_rx: directed checks of serial_negate_rx with W=8.
module tb_serial_negate_rx;
    logic       t_clk = 1'b0;
    logic       r = 1'b1;
    logic       i = 1'b0;
    logic       v = 1'b0;
    logic       f = 1'b0;
    logic       q_rdy = 1'b0;
    logic [7:0] q;
    logic       q_v, mn, fe, ovf;
    int         passed = 0;
    int         total = 0;

    serial_negate_rx #(.W(8)) dut (
        .t_clk(t_clk), .r(r), .i(i), .v(v), .f(f),
        .q(q), .q_v(q_v), .q_rdy(q_rdy), .mn(mn), .fe(fe), .ovf(ovf)
    );

    always #5 t_clk = ~t_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] val, input int lo, input int hi, input int gap);
        for (int k = lo; k <= hi; k++) begin
            i = val[k];
            v = 1'b1;
            f = (k == 0);
            tick();
            v = 1'b0;
            f = 1'b0;
            if (k != hi) repeat (gap) tick();
        end
    endtask

    task automatic consume();
        q_rdy = 1'b1;
        tick();
        q_rdy = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        r = 1'b0;
        chk("rst_q", q, 8'h00);
        chk("rst_qv", {7'b0, q_v}, 8'h00);
        chk("rst_mn", {7'b0, mn}, 8'h00);
        chk("rst_fe", {7'b0, fe}, 8'h00);
        chk("rst_ovf", {7'b0, ovf}, 8'h00);

        send_bits(8'hFB, 0, 6, 0);
        chk("fb_qv_early", {7'b0, q_v}, 8'h00);
        send_bits(8'hFB, 7, 7, 0);
        chk("fb_qv", {7'b0, q_v}, 8'h01);
        chk("fb_q", q, 8'h05);
        chk("fb_mn", {7'b0, mn}, 8'h00);
        repeat (3) tick();
        chk("fb_hold_qv", {7'b0, q_v}, 8'h01);
        chk("fb_hold_q", q, 8'h05);
        consume();
        chk("fb_consumed", {7'b0, q_v}, 8'h00);

        send_bits(8'h80, 0, 7, 0);
        chk("80_q", q, 8'h80);
        chk("80_mn", {7'b0, mn}, 8'h01);
        send_bits(8'h00, 0, 6, 0);
        q_rdy = 1'b1;
        send_bits(8'h00, 7, 7, 0);
        q_rdy = 1'b0;
        chk("00_q", q, 8'h00);
        chk("00_mn", {7'b0, mn}, 8'h00);
        chk("00_qv", {7'b0, q_v}, 8'h01);
        chk("00_ovf", {7'b0, ovf}, 8'h00);
        consume();

        send_bits(8'h01, 0, 6, 3);
        repeat (3) tick();
        chk("gap_qv_early", {7'b0, q_v}, 8'h00);
        send_bits(8'h01, 7, 7, 0);
        chk("gap_qv", {7'b0, q_v}, 8'h01);
        chk("gap_q", q, 8'hFF);
        consume();

        send_bits(8'h55, 0, 3, 0);
        send_bits(8'hFE, 0, 0, 0);
        chk("fe_pulse", {7'b0, fe}, 8'h01);
        chk("fe_no_partial", {7'b0, q_v}, 8'h00);
        send_bits(8'hFE, 1, 1, 0);
        chk("fe_one_cycle", {7'b0, fe}, 8'h00);
        send_bits(8'hFE, 2, 7, 0);
        chk("fe_word_q", q, 8'h02);
        chk("fe_word_qv", {7'b0, q_v}, 8'h01);
        consume();

        send_bits(8'h11, 0, 7, 0);
        send_bits(8'h22, 0, 7, 0);
        chk("ovf_kept_q", q, 8'hEF);
        chk("ovf_set", {7'b0, ovf}, 8'h01);
        repeat (4) tick();
        chk("ovf_sticky", {7'b0, ovf}, 8'h01);
        r = 1'b1;
        tick();
        r = 1'b0;
        chk("ovf_rst", {7'b0, ovf}, 8'h00);
        chk("ovf_rst_qv", {7'b0, q_v}, 8'h00);
        chk("ovf_rst_q", q, 8'h00);

        send_bits(8'h33, 0, 4, 0);
        i = 1'b1;
        v = 1'b1;
        r = 1'b1;
        tick();
        r = 1'b0;
        v = 1'b0;
        chk("abort_fe", {7'b0, fe}, 8'h00);
        chk("abort_ovf", {7'b0, ovf}, 8'h00);
        send_bits(8'h33, 6, 7, 0);
        chk("abort_no_word", {7'b0, q_v}, 8'h00);
        send_bits(8'hFF, 0, 7, 0);
        chk("ff_q", q, 8'h01);
        chk("ff_qv", {7'b0, q_v}, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
